// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared types for the Simon sequence checker:
//   colour_t      2-bit colour code (0=GREEN, 1=RED, 2=YELLOW, 3=BLUE)
//   chk_state_t   checker FSM state encoding
// ---------------------------------------------------------------------------
package simon_pkg;

  typedef logic [1:0] colour_t;

  localparam colour_t GREEN  = 2'd0;
  localparam colour_t RED    = 2'd1;
  localparam colour_t YELLOW = 2'd2;
  localparam colour_t BLUE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_WAIT_REL   = 3'd3,
    ST_PASS       = 3'd4,
    ST_FAIL       = 3'd5
  } chk_state_t;

endpackage : simon_pkg

// File: rtl/simon_btn_decode.sv
// ---------------------------------------------------------------------------
// simon_btn_decode
// Combinational one-hot button decoder.
// Ports:
//   btn     in  4  debounced buttons, bit i = colour i
//   valid   out 1  exactly one button is pressed
//   colour  out 2  colour of the pressed button (GREEN when not valid)
// ---------------------------------------------------------------------------
module simon_btn_decode
  import simon_pkg::*;
(
  input  logic [3:0] btn,
  output logic       valid,
  output colour_t    colour
);

  // One-hot to colour; anything else (none or several pressed) is invalid.
  always_comb begin
    valid  = 1'b0;
    colour = GREEN;
    case (btn)
      4'b0001: begin valid = 1'b1; colour = GREEN;  end
      4'b0010: begin valid = 1'b1; colour = RED;    end
      4'b0100: begin valid = 1'b1; colour = YELLOW; end
      4'b1000: begin valid = 1'b1; colour = BLUE;   end
      default: begin valid = 1'b0; colour = GREEN;  end
    endcase
  end

endmodule : simon_btn_decode

// File: rtl/simon_seq_checker.sv
// ---------------------------------------------------------------------------
// simon_seq_checker
// Stores the colour sequence from the random generator and, on start_check,
// replays it against the player's button presses, reporting pass/fail.
//
// Optional feature macro: SIMON_TIMEOUT_EN
//   defined   -> a press that does not arrive within TIMEOUT_CYCLES fails
//   undefined -> WAIT_PRESS waits indefinitely
//
// Ports:
//   CLOCK_50       in   1      system clock, rising edge
//   reset          in   1      synchronous, active-high
//   append_valid   in   1      strobe: store append_color at end of sequence
//   append_color   in   2      colour from random generator
//   start_check    in   1      strobe: begin player's turn
//   btn            in   4      debounced buttons, active-high, bit i = colour i
//   seq_len        out  LEN_W  number of stored colours
//   full           out  1      seq_len == MAX_LEN
//   checking       out  1      round in progress
//   expected_color out  2      colour at current read index (0 when not comparing)
//   round_pass     out  1      one-cycle pulse, whole sequence matched
//   round_fail     out  1      one-cycle pulse, wrong/illegal press or timeout
// ---------------------------------------------------------------------------
module simon_seq_checker
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 32,
  parameter int LEN_W          = 6,
  parameter int TIMEOUT_CYCLES = 150000000
)
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             append_valid,
  input  logic [1:0]       append_color,
  input  logic             start_check,
  input  logic [3:0]       btn,
  output logic [LEN_W-1:0] seq_len,
  output logic             full,
  output logic             checking,
  output logic [1:0]       expected_color,
  output logic             round_pass,
  output logic             round_fail
);

  localparam int              ADDR_W   = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  chk_state_t       state_r;
  chk_state_t       state_s;
  logic [LEN_W-1:0] seq_len_r;
  logic [LEN_W-1:0] idx_r;
  logic [LEN_W-1:0] idx_s;
  logic [LEN_W-1:0] idx_inc_s;
  logic             full_r;
  logic             checking_r;
  logic             pass_r;
  logic             fail_r;
  logic             append_s;
  logic             timeout_hit_s;
  colour_t          mem_r [MAX_LEN];
  colour_t          cur_colour_s;
  colour_t          expected_s;
  logic             dec_valid_s;
  colour_t          dec_colour_s;

  simon_btn_decode u_btn_decode (
    .btn    (btn),
    .valid  (dec_valid_s),
    .colour (dec_colour_s)
  );

  assign cur_colour_s = mem_r[idx_r[ADDR_W-1:0]];
  assign idx_inc_s    = idx_r + LEN_ONE;

`ifdef SIMON_TIMEOUT_EN
  localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT_CYCLES - 1);

  logic [27:0] to_cnt_r;

  // Idle-press counter: held at zero outside WAIT_PRESS, so it restarts on every entry.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      to_cnt_r <= 28'd0;
    end else if (state_r != ST_WAIT_PRESS) begin
      to_cnt_r <= 28'd0;
    end else begin
      to_cnt_r <= to_cnt_r + 28'd1;
    end
  end

  assign timeout_hit_s = (state_r == ST_WAIT_PRESS) && (to_cnt_r == TIMEOUT_LAST);
`else
  logic unused_timeout_cfg_s;

  assign timeout_hit_s        = 1'b0;
  assign unused_timeout_cfg_s = ^(32'(TIMEOUT_CYCLES));
`endif

  // Next-state, next-index and append-enable decode.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    append_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Append and start in the same cycle: the new colour joins this round.
        append_s = append_valid && !full_r;
        if (start_check) begin
          idx_s   = LEN_ZERO;
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        // An empty sequence passes at once; otherwise swallow any carried-over press.
        if (seq_len_r == LEN_ZERO) begin
          state_s = ST_PASS;
        end else if (btn == 4'b0000) begin
          state_s = ST_WAIT_PRESS;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_WAIT_PRESS: begin
        if (btn != 4'b0000) begin
          if (dec_valid_s && (dec_colour_s == cur_colour_s)) begin
            state_s = ST_WAIT_REL;
          end else begin
            state_s = ST_FAIL;
          end
        end else if (timeout_hit_s) begin
          state_s = ST_FAIL;
        end else begin
          state_s = ST_WAIT_PRESS;
        end
      end
      ST_WAIT_REL: begin
        if (btn == 4'b0000) begin
          idx_s = idx_inc_s;
          if (idx_inc_s == seq_len_r) begin
            state_s = ST_PASS;
          end else begin
            state_s = ST_WAIT_PRESS;
          end
        end else begin
          state_s = ST_WAIT_REL;
        end
      end
      ST_PASS: begin
        state_s = ST_IDLE;
      end
      ST_FAIL: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, length, index and registered status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      seq_len_r  <= LEN_ZERO;
      idx_r      <= LEN_ZERO;
      full_r     <= 1'b0;
      checking_r <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (append_s) begin
        seq_len_r <= seq_len_r + LEN_ONE;
        full_r    <= ((seq_len_r + LEN_ONE) == LEN_MAX);
      end else begin
        seq_len_r <= seq_len_r;
        full_r    <= full_r;
      end
      // checking drops in the same cycle the pass/fail pulse rises.
      checking_r <= (state_s == ST_ARM) || (state_s == ST_WAIT_PRESS) ||
                    (state_s == ST_WAIT_REL);
      pass_r     <= (state_s == ST_PASS);
      fail_r     <= (state_s == ST_FAIL);
    end
  end

  // Sequence memory write port; contents are not reset.
  always_ff @(posedge CLOCK_50) begin
    if (append_s && !reset) begin
      mem_r[seq_len_r[ADDR_W-1:0]] <= append_color;
    end else begin
      mem_r[seq_len_r[ADDR_W-1:0]] <= mem_r[seq_len_r[ADDR_W-1:0]];
    end
  end

  // Expected-colour hint is only meaningful while comparing presses.
  always_comb begin
    expected_s = GREEN;
    case (state_r)
      ST_WAIT_PRESS: expected_s = cur_colour_s;
      ST_WAIT_REL:   expected_s = cur_colour_s;
      default:       expected_s = GREEN;
    endcase
  end

  assign seq_len        = seq_len_r;
  assign full           = full_r;
  assign checking       = checking_r;
  assign expected_color = expected_s;
  assign round_pass     = pass_r;
  assign round_fail     = fail_r;

endmodule : simon_seq_checker

// File: tb/tb_simon_seq_checker.sv
module tb_simon_seq_checker;

  logic       clk;
  logic       reset;
  logic       append_valid;
  logic [1:0] append_color;
  logic       start_check;
  logic [3:0] btn;
  logic [5:0] seq_len;
  logic       full;
  logic       checking;
  logic [1:0] expected_color;
  logic       round_pass;
  logic       round_fail;

  int errors = 0;
  int checks = 0;

  simon_seq_checker #(
    .MAX_LEN        (32),
    .LEN_W          (6),
    .TIMEOUT_CYCLES (150000000)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .append_valid   (append_valid),
    .append_color   (append_color),
    .start_check    (start_check),
    .btn            (btn),
    .seq_len        (seq_len),
    .full           (full),
    .checking       (checking),
    .expected_color (expected_color),
    .round_pass     (round_pass),
    .round_fail     (round_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       av;
    logic [1:0] ac;
    logic       st;
    logic [3:0] b;
    logic [5:0] e_len;
    logic       e_full;
    logic       e_chk;
    logic [1:0] e_col;
    logic       e_pass;
    logic       e_fail;
  } vec_t;

  vec_t tbl[$];

  task automatic add(string n, logic rst, logic av, logic [1:0] ac, logic st,
                     logic [3:0] b, int len, logic fl, logic chk, logic [1:0] col,
                     logic p, logic f);
    vec_t v;
    v.name = n; v.rst = rst; v.av = av; v.ac = ac; v.st = st; v.b = b;
    v.e_len = 6'(len); v.e_full = fl; v.e_chk = chk; v.e_col = col;
    v.e_pass = p; v.e_fail = f;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {seq_len, full, checking, expected_color, round_pass, round_fail};
  endfunction

  function automatic logic [1:0] col_of(int i);
    return 2'((i + i / 4) % 4);
  endfunction

  initial begin
    logic [3:0] onehot;
    logic       seen_fail;

    reset = 1'b1; append_valid = 1'b0; append_color = 2'd0;
    start_check = 1'b0; btn = 4'd0;
    step(); step();
    chk("reset_state", 32'(outs()), 32'h0);
    reset = 1'b0;

    //   name         rst av ac st btn      len fl ck col p f
    // Round 1: sequence G,Y,B played correctly; append/start during round ignored
    add("t1_app0",   0, 1, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add("t1_app2",   0, 1, 2, 0, 4'b0000, 2, 0, 0, 0, 0, 0);
    add("t1_app3",   0, 1, 3, 0, 4'b0000, 3, 0, 0, 0, 0, 0);
    add("t1_start",  0, 0, 0, 1, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t1_arm",    0, 0, 0, 0, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t1_p0",     0, 0, 0, 0, 4'b0001, 3, 0, 1, 0, 0, 0);
    add("t1_r0",     0, 0, 0, 0, 4'b0000, 3, 0, 1, 2, 0, 0);
    add("t1_p1_app", 0, 1, 1, 0, 4'b0100, 3, 0, 1, 2, 0, 0);
    add("t1_r1",     0, 0, 0, 0, 4'b0000, 3, 0, 1, 3, 0, 0);
    add("t1_p2_st",  0, 0, 0, 1, 4'b1000, 3, 0, 1, 3, 0, 0);
    add("t1_pass",   0, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 1, 0);
    add("t1_idle",   0, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0);
    // Round 2: wrong colour on second press
    add("t2_start",  0, 0, 0, 1, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t2_arm",    0, 0, 0, 0, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t2_p0",     0, 0, 0, 0, 4'b0001, 3, 0, 1, 0, 0, 0);
    add("t2_r0",     0, 0, 0, 0, 4'b0000, 3, 0, 1, 2, 0, 0);
    add("t2_bad",    0, 0, 0, 0, 4'b0010, 3, 0, 0, 0, 0, 1);
    add("t2_idle",   0, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0);
    // Round 3: button held over start is not compared; two-hot press fails
    add("t3_st_held",0, 0, 0, 1, 4'b1000, 3, 0, 1, 0, 0, 0);
    add("t3_held1",  0, 0, 0, 0, 4'b1000, 3, 0, 1, 0, 0, 0);
    add("t3_held2",  0, 0, 0, 0, 4'b1000, 3, 0, 1, 0, 0, 0);
    add("t3_rel",    0, 0, 0, 0, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t3_twohot", 0, 0, 0, 0, 4'b0101, 3, 0, 0, 0, 0, 1);
    add("t3_idle",   0, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0);
    // Round 4: reset while waiting for release aborts silently
    add("t6_start",  0, 0, 0, 1, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t6_arm",    0, 0, 0, 0, 4'b0000, 3, 0, 1, 0, 0, 0);
    add("t6_p0",     0, 0, 0, 0, 4'b0001, 3, 0, 1, 0, 0, 0);
    add("t6_reset",  1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
    add("t6_after1", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add("t6_after2", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    // Empty sequence passes within two cycles
    add("t5_start0", 0, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0, 0);
    add("t5_pass0",  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0);
    add("t5_idle0",  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    // Append and start in the same cycle: round of length 1
    add("t5_appst",  0, 1, 1, 1, 4'b0000, 1, 0, 1, 0, 0, 0);
    add("t5_arm",    0, 0, 0, 0, 4'b0000, 1, 0, 1, 1, 0, 0);
    add("t5_p0",     0, 0, 0, 0, 4'b0010, 1, 0, 1, 1, 0, 0);
    add("t5_pass1",  0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 1, 0);
    add("t5_idle1",  0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; append_valid = tbl[i].av; append_color = tbl[i].ac;
      start_check = tbl[i].st; btn = tbl[i].b;
      step();
      chk(tbl[i].name, 32'(outs()),
          32'({tbl[i].e_len, tbl[i].e_full, tbl[i].e_chk, tbl[i].e_col,
               tbl[i].e_pass, tbl[i].e_fail}));
    end
    reset = 1'b0; append_valid = 1'b0; start_check = 1'b0; btn = 4'd0;

    // Fill to capacity; the 33rd colour must be dropped (and must not wrap onto slot 0)
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      append_valid = 1'b1; append_color = col_of(i);
      step();
      if (i == 30) chk("fill_31", 32'({seq_len, full}), 32'({6'd31, 1'b0}));
      if (i == 31) chk("fill_32", 32'({seq_len, full}), 32'({6'd32, 1'b1}));
    end
    append_color = 2'd2;
    step();
    chk("fill_33_ignored", 32'({seq_len, full}), 32'({6'd32, 1'b1}));
    append_valid = 1'b0;
    start_check = 1'b1; step(); start_check = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("full_exp_%0d", i), 32'(expected_color), 32'(col_of(i)));
      onehot = 4'b0001 << col_of(i);
      btn = onehot; step();
      btn = 4'd0; step();
      if (i < 31)
        chk($sformatf("full_mid_%0d", i), 32'({checking, round_pass, round_fail}), 32'(3'b100));
      else
        chk("full_pass", 32'({seq_len, checking, round_pass, round_fail}),
            32'({6'd32, 3'b010}));
    end
    step();
    chk("full_pulse_end", 32'({round_pass, round_fail}), 32'(2'b00));

    // Long idle in WAIT_PRESS must not produce a fail
    start_check = 1'b1; step(); start_check = 1'b0;
    step();
    seen_fail = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (round_fail) seen_fail = 1'b1;
    end
    chk("idle_wait_no_fail", 32'({checking, seen_fail}), 32'(2'b10));
    reset = 1'b1; step(); reset = 1'b0;
    chk("final_reset", 32'(outs()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_simon_seq_checker
